pci_initiator: RTL and testbench

- Bus-master stage that sits directly upstream of the PCI target buffer block.
- Drives frame, CBE, AD and IRDY, and consumes TRDY to run single-burst READ (4'b0110) and WRITE (4'b0111) transactions of 1–4 data phases.
- Host side: a 4-entry write-data FIFO loaded before a transaction, plus a per-word read-data strobe, so the GUI/testbench can issue bursts without driving bus timing itself.

---
 rtl/pci_pkg.sv | 23 ++
 rtl/pci_wbuf.sv | 59 +++++
 rtl/pci_initiator.sv | 156 +++++++++++++++
 tb/tb_pci_initiator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI initiator slice.
//   CMD_READ / CMD_WRITE : bus commands driven on CBE in the address phase
//   BE_ALL               : byte enables used in every data phase (all lanes on)
//   pci_state_e          : initiator bus-phase state
//   pci_req_t            : transaction parameters latched when a start is accepted
package pci_pkg;

  localparam logic [3:0] CMD_READ  = 4'b0110;
  localparam logic [3:0] CMD_WRITE = 4'b0111;
  localparam logic [3:0] BE_ALL    = 4'b0000;

  typedef enum logic [2:0] {IDLE, ADDR, TURN, DATA, RECOVER} pci_state_e;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
  } pci_req_t;

  function automatic logic [3:0] cmd_of(input logic rw);
    return rw ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/pci_wbuf.sv
// Write-data FIFO feeding the initiator's write data phases.
//   clk, rst   : clock, async active-high reset (empties the FIFO)
//   push, din  : enqueue din; ignored when full
//   pop        : dequeue head; ignored when empty
//   dout       : current head word (valid while not empty)
//   count      : words held
//   full/empty : status
module pci_wbuf #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [31:0]   din,
  input  logic          pop,
  output logic [31:0]   dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          wp, rp;
  logic                   do_push, do_pop;

  // Explicit wrap so non-power-of-two depths still cycle through every slot.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pci_initiator.sv
// PCI bus-master stage: runs single READ/WRITE bursts of 1..DEPTH words.
//   clk, rst            : clock, async active-high reset
//   start/rw/addr/nwords: transaction request, sampled together in IDLE
//   wr_en/wdata         : push into the write-data FIFO (any time)
//   frame/CBE/AD/IRDY   : bus outputs; AD is tri-stated unless we own it
//   TRDY                : target ready (low = word moves on this edge)
//   rdata/rdata_valid   : captured read word plus one-cycle strobe
//   busy/done/abort/err : status; done/abort/err are one-cycle pulses
//   fifo_count          : words waiting in the write FIFO
module pci_initiator import pci_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [2:0]  nwords,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic        frame,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  output logic        IRDY,
  input  logic        TRDY,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic        err,
  output logic [2:0]  fifo_count
);

  localparam int         WW   = $clog2(TIMEOUT + 1);
  localparam logic [2:0] MAXW = 3'(DEPTH);

  pci_state_e    state, nstate;
  pci_req_t      req_q;
  logic [2:0]    rem;
  logic [WW-1:0] wcnt;
  logic          ab_q, err_q;

  logic [31:0]   fifo_head, ad_out;
  logic          fifo_full, fifo_empty, fifo_ovf, pop;
  logic          xfer, tmo, start_ok, reject, ad_oe;

  pci_wbuf #(.DEPTH(DEPTH), .CW(3)) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .din   (wdata),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A write may only start once its whole burst is already buffered, so the
  // data phases never have to stall on an empty FIFO.
  assign start_ok = start && (nwords != 3'd0) && (nwords <= MAXW) &&
                    (!rw || (fifo_count >= nwords));
  assign reject   = (state == IDLE) && start && !start_ok;
  assign fifo_ovf = wr_en && fifo_full;

  assign xfer = (state == DATA) && !TRDY;
  // Abort on the TIMEOUT-th consecutive stalled data cycle; no word moves then.
  assign tmo  = (state == DATA) && TRDY && (wcnt == WW'(TIMEOUT - 1));
  assign pop  = xfer && req_q.rw && !fifo_empty;

  assign AD = ad_oe ? ad_out : 'z;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nstate;

  always_comb begin
    nstate = state;
    frame  = 1'b1;
    IRDY   = 1'b1;
    CBE    = BE_ALL;
    ad_oe  = 1'b0;
    ad_out = fifo_head;
    busy   = 1'b0;
    done   = 1'b0;
    abort  = 1'b0;
    unique case (state)
      IDLE: if (start_ok) nstate = ADDR;
      ADDR: begin
        frame  = 1'b0;
        CBE    = cmd_of(req_q.rw);
        ad_oe  = 1'b1;
        ad_out = req_q.addr;
        busy   = 1'b1;
        nstate = req_q.rw ? DATA : TURN;
      end
      TURN: begin
        frame  = 1'b0;
        IRDY   = 1'b0;
        busy   = 1'b1;
        nstate = DATA;
      end
      DATA: begin
        // frame drops away during the last data phase
        frame = (rem == 3'd1);
        IRDY  = 1'b0;
        ad_oe = req_q.rw;
        busy  = 1'b1;
        abort = tmo;
        if (tmo || (xfer && rem == 3'd1)) nstate = RECOVER;
      end
      RECOVER: begin
        done   = !ab_q;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      rem         <= '0;
      wcnt        <= '0;
      ab_q        <= 1'b0;
      err_q       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      err_q       <= reject || fifo_ovf;
      rdata_valid <= xfer && !req_q.rw;
      if (xfer && !req_q.rw) rdata <= AD;
      if (state == IDLE && start_ok) begin
        req_q <= '{rw: rw, addr: addr};
        rem   <= nwords;
        wcnt  <= '0;
        ab_q  <= 1'b0;
      end
      if (state == DATA) begin
        if (xfer) begin
          rem  <= rem - 1'b1;
          wcnt <= '0;
        end else if (tmo) begin
          ab_q <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_pci_initiator.sv
module tb_pci_initiator;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 0, rw = 0, wr_en = 0, TRDY = 1;
  logic [31:0] addr = 0, wdata = 0, tb_ad = 0;
  logic [2:0]  nwords = 0;
  logic        tb_oe = 0;
  wire  [31:0] AD;
  logic        frame, IRDY, rdata_valid, busy, done, abort, err;
  logic [3:0]  CBE;
  logic [31:0] rdata;
  logic [2:0]  fifo_count;

  int n_chk = 0, n_err = 0;
  logic [31:0] q[$];   // model of the write FIFO contents

  assign AD = tb_oe ? tb_ad : 'z;

  pci_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .nwords(nwords),
    .wr_en(wr_en), .wdata(wdata), .frame(frame), .CBE(CBE), .AD(AD), .IRDY(IRDY),
    .TRDY(TRDY), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
    .done(done), .abort(abort), .err(err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Bench drives a random probe; reading it back proves the DUT released AD.
  task automatic probe_ad(output logic [31:0] p);
    p = $urandom; tb_oe = 1; tb_ad = p;
  endtask

  task automatic push(input logic [31:0] w);
    bit ovf;
    ovf = (q.size() == DEPTH);
    wr_en = 1; wdata = w;
    nxt();
    wr_en = 0;
    if (!ovf) q.push_back(w);
    chk("push_err", err, 32'(ovf));
    chk("push_cnt", fifo_count, q.size());
  endtask

  // One transaction, checked phase by phase against the bus protocol rules.
  task automatic txn(input bit w, input logic [31:0] a, input int n,
                     input int stall, input int fwait, input logic [31:0] rbase);
    bit ok, ovf, pushed;
    int left, waits, guard;
    logic [31:0] word, p, pw;
    ok = (n >= 1) && (n <= DEPTH) && (!w || q.size() >= n);
    rw = w; addr = a; nwords = 3'(n); start = 1;
    nxt();
    start = 0;
    if (!ok) begin
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 0);
      @(negedge clk);
      chk("rej_frame", frame, 1);
      chk("rej_cnt", fifo_count, q.size());
      nxt();
      chk("rej_err_clr", err, 0);
      return;
    end
    start = 1; nwords = 3'd0;          // must be ignored while busy
    @(negedge clk);
    chk("addr_frame", frame, 0);
    chk("addr_irdy", IRDY, 1);
    chk("addr_cbe", CBE, w ? 4'b0111 : 4'b0110);
    chk("addr_ad", AD, a);
    chk("addr_busy", busy, 1);
    nxt();
    start = 0;
    chk("busy_start_err", err, 0);
    if (!w) begin
      probe_ad(p);
      @(negedge clk);
      chk("turn_frame", frame, 0);
      chk("turn_irdy", IRDY, 0);
      chk("turn_cbe", CBE, 0);
      chk("turn_ad", AD, p);
      nxt();
    end
    left = n; waits = 0; guard = 0; word = 0;
    while (left > 0 && guard < 100) begin
      guard++;
      TRDY = ((n - left) == 1 && waits < fwait) ||
             (waits < TIMEOUT - 2 && $urandom_range(99) < stall);
      if (!w) begin
        word = (rbase != 0) ? rbase + 32'(n - left) : $urandom;
        tb_oe = 1; tb_ad = word;
      end
      pushed = (stall > 0) && ($urandom_range(3) == 0);
      ovf = pushed && (q.size() == DEPTH);
      pw = $urandom; wr_en = pushed; wdata = pw;
      @(negedge clk);
      chk("d_irdy", IRDY, 0);
      chk("d_frame", frame, 32'(left == 1));
      chk("d_cbe", CBE, 0);
      chk("d_busy", busy, 1);
      chk("d_abort", abort, 0);
      if (w) chk("d_ad", AD, q[0]);
      nxt();
      wr_en = 0;
      if (!TRDY) begin
        if (w) void'(q.pop_front());
        else begin
          chk("rd_vld", rdata_valid, 1);
          chk("rd_data", rdata, word);
        end
        left--; waits = 0;
      end else begin
        waits++;
        if (!w) chk("rd_vld_idle", rdata_valid, 0);
      end
      if (pushed && !ovf) q.push_back(pw);
      if (pushed) chk("d_push_err", err, 32'(ovf));
    end
    chk("txn_left", left, 0);
    TRDY = 1;
    probe_ad(p);
    @(negedge clk);
    chk("rec_done", done, 1);
    chk("rec_frame", frame, 1);
    chk("rec_irdy", IRDY, 1);
    chk("rec_busy", busy, 0);
    chk("rec_abort", abort, 0);
    chk("rec_ad", AD, p);
    chk("rec_cnt", fifo_count, q.size());
    nxt();
    tb_oe = 0;
    chk("idle_done", done, 0);
  endtask

  initial begin
    logic [31:0] p;
    probe_ad(p);
    #12;
    chk("rst_frame", frame, 1);
    chk("rst_irdy", IRDY, 1);
    chk("rst_cbe", CBE, 0);
    chk("rst_ad", AD, p);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_err", err, 0);
    chk("rst_vld", rdata_valid, 0);
    chk("rst_cnt", fifo_count, 0);
    @(negedge clk); rst = 0; tb_oe = 0;
    nxt();

    // write burst
    for (int i = 1; i <= 4; i++) push(32'h11111111 * i);
    txn(1, 32'h100, 4, 0, 0, 0);
    chk("t1_cnt", fifo_count, 0);
    // read burst
    txn(0, 32'h200, 4, 0, 0, 32'hA0);
    // wait states before the second word
    push(32'hCAFE0001); push(32'hCAFE0002);
    txn(1, 32'h300, 2, 0, 3, 0);

    // timeout: TRDY stuck high
    push(32'hDEAD0001); push(32'hDEAD0002);
    rw = 1; addr = 32'h400; nwords = 3'd2; start = 1;
    nxt(); start = 0;
    nxt();                               // leave the address phase
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      chk("tmo_abort", abort, 32'(k == TIMEOUT));
      chk("tmo_irdy", IRDY, 0);
      nxt();
    end
    probe_ad(p);
    @(negedge clk);
    chk("tmo_frame", frame, 1);
    chk("tmo_irdy_rel", IRDY, 1);
    chk("tmo_done", done, 0);
    chk("tmo_abort_clr", abort, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_ad", AD, p);
    chk("tmo_cnt", fifo_count, 2);
    nxt(); tb_oe = 0;

    // rejections: short FIFO, then overflow
    txn(1, 32'h500, 3, 0, 0, 0);
    txn(0, 32'h500, 0, 0, 0, 0);
    txn(0, 32'h500, 5, 0, 0, 0);
    push(32'hBEEF0003); push(32'hBEEF0004); push(32'hBEEF0005);
    chk("ovf_cnt", fifo_count, 4);
    txn(1, 32'h600, 4, 0, 0, 0);

    // reset in the middle of a write burst
    for (int i = 0; i < 4; i++) push($urandom);
    rw = 1; addr = 32'h700; nwords = 3'd4; start = 1;
    nxt(); start = 0;
    nxt(); TRDY = 0;
    nxt(); TRDY = 1;
    #2 rst = 1; probe_ad(p);
    #1;
    chk("mrst_frame", frame, 1);
    chk("mrst_irdy", IRDY, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", fifo_count, 0);
    chk("mrst_ad", AD, p);
    q.delete();
    @(negedge clk); rst = 0; tb_oe = 0;
    nxt();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int np;
      np = $urandom_range(0, 3);
      for (int j = 0; j < np; j++) push($urandom);
      txn(1'($urandom_range(1)), $urandom, $urandom_range(0, 5), 30, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
